bus_router: RTL and testbench
=============================

Name: bus_router

Overview:
- Registered, parametrised successor to the combinational address decoder.
- Routes one outstanding CPU load/store to one of NUM_SLAVES address windows (RAM, CNN, GPIO, spare) and sequences a request/acknowledge handshake with each slave.
- Adds read-data return muxing, a per-access timeout, and an error response for unmapped addresses or slaves that never acknowledge.
- Sits between the core's data port and the memory-mapped peripherals.

Parameters:
- NUM_SLAVES, 4: number of slave windows, 1..8.
- ADDR_W, 32: address width.
- DATA_W, 32: data width.
- SLV_BASE, {32'hF000_0000, 32'hC000_0000, 32'h0000_0000, 32'h0}: packed NUM_SLAVES*ADDR_W inclusive base addresses; slave i at bits [i*ADDR_W +: ADDR_W]. Slot 0 is the spare.
- SLV_LIMIT, {32'hF000_1000, 32'hC000_1000, 32'hA000_0000, 32'h0}: packed exclusive limits. Base == limit disables a slot.
- TIMEOUT, 16: maximum cycles spent in ACCESS before an error response, at least 2.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- wr_req  in  1  write request.
- rd_req  in  1  read request.
- w_addr  in  ADDR_W  write address.
- r_addr  in  ADDR_W  read address.
- m_wdata  in  DATA_W  write data.
- m_wstrb  in  DATA_W/8  byte enables.
- m_rdata  out  DATA_W  read data, valid while m_ready=1.
- m_ready  out  1  one-cycle completion pulse.
- m_err  out  1  error flag, qualified by m_ready.
- busy  out  1  high in ACCESS or RESP.
- s_sel  out  NUM_SLAVES  one-hot slave select.
- s_we  out  1  write enable to slaves.
- s_addr  out  ADDR_W  registered address to slaves.
- s_wdata  out  DATA_W  registered write data.
- s_wstrb  out  DATA_W/8  registered byte enables.
- s_rdata  in  NUM_SLAVES*DATA_W  packed slave read data.
- s_ack  in  NUM_SLAVES  per-slave acknowledge.

Behaviour:
- Reset values: state=IDLE; all outputs 0 (s_sel=0, m_ready=0, m_err=0, busy=0, m_rdata=0, s_addr/s_wdata/s_wstrb=0, s_we=0); timeout counter 0.
- Reset mid-transaction aborts immediately: s_sel drops asynchronously and no response is issued.
- Target selection: write has priority. If wr_req, target = w_addr with we=1; else if rd_req, target = r_addr with we=0.
- Decode: hit[i] = (base_i <= target < limit_i) && (base_i != limit_i). The lowest index wins on overlap. Comparisons are unsigned and full ADDR_W.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If any request is present, register target, we, m_wdata and m_wstrb into s_*.
  - If a slot hits, register the one-hot s_sel and go to ACCESS.
  - If nothing hits, go to RESP with err=1 and m_rdata=0. s_sel stays 0 and no slave sees the access.
  - With no request, remain in IDLE.
- ACCESS:
  - s_sel, s_we, s_addr, s_wdata and s_wstrb are held stable.
  - The counter increments each cycle.
  - If s_ack[sel]=1: capture that slave's s_rdata slice (0 for writes), clear s_sel, go to RESP with err=0.
  - Else if counter == TIMEOUT-1: clear s_sel, go to RESP with err=1 and m_rdata=0.
  - An ack on the final cycle wins over the timeout.
  - Acks from unselected slaves are ignored.
- RESP:
  - m_ready=1 for exactly one cycle, with m_rdata and m_err valid.
  - Counter cleared; return to IDLE.
  - Requests present in ACCESS or RESP are ignored. The master holds or reissues after m_ready, so at least one idle cycle falls between transactions.
- Latency: a request in IDLE at cycle N gives s_sel at N+1. An ack at N+1 gives m_ready at N+2. An unmapped access gives m_ready at N+1.
- m_rdata and m_err hold their last values outside RESP; masters must sample only while m_ready=1.

Test Plan:
- Read at r_addr=0x0000_1000 (rd_req=1), s_ack[1] at cycle 1 with s_rdata[1]=0x1234_5678 -> s_sel=4'b0010 at cycle 1; m_ready=1, m_rdata=0x1234_5678, m_err=0 at cycle 2.
- Simultaneous wr_req with w_addr=0xC000_0004 and rd_req with r_addr=0x0 -> s_sel=4'b0100, s_we=1, s_addr=0xC000_0004; the read is dropped.
- Read at 0xB000_0000 (unmapped) -> s_sel stays 0; m_ready=1, m_err=1, m_rdata=0 the next cycle.
- Write to 0xF000_0010 with s_ack never asserted, TIMEOUT=16 -> s_sel=4'b1000 for exactly 16 cycles, then an m_ready pulse with m_err=1.
- s_ack[2] pulsed while slave 1 is selected, then s_ack[1] three cycles later -> the stray ack is ignored; m_ready comes 1 cycle after s_ack[1]; busy=1 throughout.
- rst asserted during ACCESS -> s_sel=0 and busy=0 immediately; no m_ready pulse after release; the next request is handled normally.

Source files
------------

// File: rtl/bus_router.sv
// ---------------------------------------------------------------------------
// bus_router
//
// Registered address router between the core's data port and the
// memory-mapped peripherals. A single outstanding load or store is decoded
// against NUM_SLAVES address windows. The router then holds a one-hot select
// towards the chosen slave until that slave acknowledges or the access times
// out. Finally it returns a one-cycle completion pulse to the master, with
// the read data and an error flag.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   wr_req, w_addr    write request and address (priority over reads)
//   rd_req, r_addr    read request and address
//   m_wdata, m_wstrb  master write data and byte enables
//   m_rdata, m_err    response data / error, valid while m_ready=1
//   m_ready           one-cycle completion pulse
//   busy              transaction in flight (ACCESS or RESP)
//   s_sel             one-hot slave select, held for the whole access
//   s_we, s_addr      registered write enable and address to slaves
//   s_wdata, s_wstrb  registered write data and byte enables to slaves
//   s_rdata           packed slave read data, slave i at [i*DATA_W +: DATA_W]
//   s_ack             per-slave acknowledge
// ---------------------------------------------------------------------------
module bus_router #(
    parameter int NUM_SLAVES = 4,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE  =
        {32'hF000_0000, 32'hC000_0000, 32'h0000_0000, 32'h0000_0000},
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_LIMIT =
        {32'hF000_1000, 32'hC000_1000, 32'hA000_0000, 32'h0000_0000},
    parameter int TIMEOUT    = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_req,
    input  logic                         rd_req,
    input  logic [ADDR_W-1:0]            w_addr,
    input  logic [ADDR_W-1:0]            r_addr,
    input  logic [DATA_W-1:0]            m_wdata,
    input  logic [DATA_W/8-1:0]          m_wstrb,
    output logic [DATA_W-1:0]            m_rdata,
    output logic                         m_ready,
    output logic                         m_err,
    output logic                         busy,
    output logic [NUM_SLAVES-1:0]        s_sel,
    output logic                         s_we,
    output logic [ADDR_W-1:0]            s_addr,
    output logic [DATA_W-1:0]            s_wdata,
    output logic [DATA_W/8-1:0]          s_wstrb,
    input  logic [NUM_SLAVES*DATA_W-1:0] s_rdata,
    input  logic [NUM_SLAVES-1:0]        s_ack
);

    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t                  state_r;
    logic [CNT_W-1:0]        cnt_r;
    logic [NUM_SLAVES-1:0]   s_sel_r;
    logic                    s_we_r;
    logic [ADDR_W-1:0]       s_addr_r;
    logic [DATA_W-1:0]       s_wdata_r;
    logic [STRB_W-1:0]       s_wstrb_r;
    logic [DATA_W-1:0]       m_rdata_r;
    logic                    m_ready_r;
    logic                    m_err_r;
    logic                    busy_r;

    logic                    req_s;
    logic [ADDR_W-1:0]       tgt_addr_s;
    logic                    tgt_we_s;
    logic [NUM_SLAVES-1:0]   hit_s;
    logic [NUM_SLAVES-1:0]   sel_s;
    logic                    ack_s;
    logic [DATA_W-1:0]       rdata_mux_s;
    logic [DATA_W-1:0]       rdata_ret_s;

    assign req_s = wr_req | rd_req;

    // Pick the request to serve: writes win over simultaneous reads.
    always_comb begin
        if (wr_req) begin
            tgt_addr_s = w_addr;
            tgt_we_s   = 1'b1;
        end else begin
            tgt_addr_s = r_addr;
            tgt_we_s   = 1'b0;
        end
    end

    // Window decode; a slot whose base equals its limit is disabled.
    always_comb begin
        hit_s = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            hit_s[i] = (tgt_addr_s >= SLV_BASE[i*ADDR_W +: ADDR_W]) &&
                       (tgt_addr_s <  SLV_LIMIT[i*ADDR_W +: ADDR_W]) &&
                       (SLV_BASE[i*ADDR_W +: ADDR_W] != SLV_LIMIT[i*ADDR_W +: ADDR_W]);
        end
    end

    // Keep only the lowest set hit bit so overlapping windows resolve to the lowest index.
    assign sel_s = hit_s & (~hit_s + {{(NUM_SLAVES-1){1'b0}}, 1'b1});

    // Only the acknowledge of the currently selected slave counts.
    assign ack_s = |(s_ack & s_sel_r);

    // Return-data mux driven by the held one-hot select.
    always_comb begin
        rdata_mux_s = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (s_sel_r[i]) begin
                rdata_mux_s = rdata_mux_s | s_rdata[i*DATA_W +: DATA_W];
            end else begin
                rdata_mux_s = rdata_mux_s;
            end
        end
    end

    // Writes return zero data regardless of what the slave drives.
    always_comb begin
        if (s_we_r) begin
            rdata_ret_s = '0;
        end else begin
            rdata_ret_s = rdata_mux_s;
        end
    end

    // Transaction FSM together with every registered output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= '0;
            s_sel_r   <= '0;
            s_we_r    <= 1'b0;
            s_addr_r  <= '0;
            s_wdata_r <= '0;
            s_wstrb_r <= '0;
            m_rdata_r <= '0;
            m_ready_r <= 1'b0;
            m_err_r   <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    m_ready_r <= 1'b0;
                    cnt_r     <= '0;
                    if (req_s) begin
                        s_addr_r  <= tgt_addr_s;
                        s_we_r    <= tgt_we_s;
                        s_wdata_r <= m_wdata;
                        s_wstrb_r <= m_wstrb;
                        busy_r    <= 1'b1;
                        if (|sel_s) begin
                            s_sel_r <= sel_s;
                            state_r <= ST_ACCESS;
                        end else begin
                            // Unmapped: answer straight away, no slave is touched.
                            s_sel_r   <= '0;
                            m_rdata_r <= '0;
                            m_err_r   <= 1'b1;
                            m_ready_r <= 1'b1;
                            state_r   <= ST_RESP;
                        end
                    end
                end
                ST_ACCESS: begin
                    // Ack is checked first so an ack on the last allowed cycle still succeeds.
                    if (ack_s) begin
                        m_rdata_r <= rdata_ret_s;
                        m_err_r   <= 1'b0;
                        m_ready_r <= 1'b1;
                        s_sel_r   <= '0;
                        cnt_r     <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                        state_r   <= ST_RESP;
                    end else if (cnt_r == CNT_W'(TIMEOUT - 1)) begin
                        m_rdata_r <= '0;
                        m_err_r   <= 1'b1;
                        m_ready_r <= 1'b1;
                        s_sel_r   <= '0;
                        cnt_r     <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                        state_r   <= ST_RESP;
                    end else begin
                        cnt_r     <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_RESP: begin
                    m_ready_r <= 1'b0;
                    busy_r    <= 1'b0;
                    cnt_r     <= '0;
                    state_r   <= ST_IDLE;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    cnt_r     <= '0;
                    s_sel_r   <= '0;
                    m_ready_r <= 1'b0;
                    busy_r    <= 1'b0;
                end
            endcase
        end
    end

    assign s_sel   = s_sel_r;
    assign s_we    = s_we_r;
    assign s_addr  = s_addr_r;
    assign s_wdata = s_wdata_r;
    assign s_wstrb = s_wstrb_r;
    assign m_rdata = m_rdata_r;
    assign m_ready = m_ready_r;
    assign m_err   = m_err_r;
    assign busy    = busy_r;

endmodule

// File: tb/tb_bus_router.sv
// ---------------------------------------------------------------------------
// tb_bus_router
//
// Self-checking bench for bus_router with its default windows:
//   slot 1: [0x0000_0000, 0xA000_0000)  slot 2: [0xC000_0000, 0xC000_1000)
//   slot 3: [0xF000_0000, 0xF000_1000)  slot 0: disabled
// Each issued request pushes its expected {err, rdata} onto a scoreboard
// queue. A monitor pops and compares on every m_ready pulse. The scenario
// tasks also check select, latency and handshake behaviour inline.
// ---------------------------------------------------------------------------
module tb_bus_router;

    localparam int NS = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 16;

    logic              clk;
    logic              rst;
    logic              wr_req;
    logic              rd_req;
    logic [AW-1:0]     w_addr;
    logic [AW-1:0]     r_addr;
    logic [DW-1:0]     m_wdata;
    logic [SW-1:0]     m_wstrb;
    logic [DW-1:0]     m_rdata;
    logic              m_ready;
    logic              m_err;
    logic              busy;
    logic [NS-1:0]     s_sel;
    logic              s_we;
    logic [AW-1:0]     s_addr;
    logic [DW-1:0]     s_wdata;
    logic [SW-1:0]     s_wstrb;
    logic [NS*DW-1:0]  s_rdata;
    logic [NS-1:0]     s_ack;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW:0] exp_q[$];
    logic [DW:0] sb_exp;

    bus_router #(
        .NUM_SLAVES (NS),
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .TIMEOUT    (TO)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_req  (wr_req),
        .rd_req  (rd_req),
        .w_addr  (w_addr),
        .r_addr  (r_addr),
        .m_wdata (m_wdata),
        .m_wstrb (m_wstrb),
        .m_rdata (m_rdata),
        .m_ready (m_ready),
        .m_err   (m_err),
        .busy    (busy),
        .s_sel   (s_sel),
        .s_we    (s_we),
        .s_addr  (s_addr),
        .s_wdata (s_wdata),
        .s_wstrb (s_wstrb),
        .s_rdata (s_rdata),
        .s_ack   (s_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard monitor: every completion must match the oldest pending expectation.
    always @(negedge clk) begin
        if (rst === 1'b0 && m_ready === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: m_ready pulse with nothing pending, got err=%b rdata=%h",
                         m_err, m_rdata);
            end else begin
                sb_exp = exp_q.pop_front();
                if ({m_err, m_rdata} !== sb_exp) begin
                    n_fail++;
                    $display("FAIL sb_response: got err=%b rdata=%h, expected err=%b rdata=%h",
                             m_err, m_rdata, sb_exp[DW], sb_exp[DW-1:0]);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        wr_req  = 1'b0;
        rd_req  = 1'b0;
        w_addr  = '0;
        r_addr  = '0;
        m_wdata = '0;
        m_wstrb = '0;
        s_rdata = '0;
        s_ack   = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        #2;
        n_checks++;
        if ({s_sel, m_ready, m_err, busy, s_we} !== 8'h00 || m_rdata !== 32'h0 ||
            s_addr !== 32'h0 || s_wdata !== 32'h0 || s_wstrb !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_values: sel=%b rdy=%b err=%b busy=%b we=%b rdata=%h addr=%h wdata=%h wstrb=%h, expected all 0",
                     s_sel, m_ready, m_err, busy, s_we, m_rdata, s_addr, s_wdata, s_wstrb);
        end
        step();
        step();
        rst = 1'b0;
        step();
        n_checks++;
        if ({s_sel, m_ready, busy} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_release: sel=%b rdy=%b busy=%b, expected 0 0 0", s_sel, m_ready, busy);
        end
    endtask

    task automatic test_read();
        rd_req = 1'b1;
        r_addr = 32'h0000_1000;
        exp_q.push_back({1'b0, 32'h1234_5678});
        step();
        rd_req = 1'b0;
        n_checks++;
        if (s_sel !== 4'b0010 || s_we !== 1'b0 || s_addr !== 32'h0000_1000 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL read_select: sel=%b we=%b addr=%h busy=%b, expected 0010 0 00001000 1",
                     s_sel, s_we, s_addr, busy);
        end
        s_ack[1] = 1'b1;
        s_rdata[1*DW +: DW] = 32'h1234_5678;
        step();
        s_ack = '0;
        n_checks++;
        if (m_ready !== 1'b1 || m_rdata !== 32'h1234_5678 || m_err !== 1'b0 || s_sel !== 4'b0000) begin
            n_fail++;
            $display("FAIL read_response: rdy=%b rdata=%h err=%b sel=%b, expected 1 12345678 0 0000",
                     m_ready, m_rdata, m_err, s_sel);
        end
        step();
        n_checks++;
        if (m_ready !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL read_pulse_width: rdy=%b busy=%b, expected 0 0", m_ready, busy);
        end
    endtask

    task automatic test_unmapped();
        rd_req = 1'b1;
        r_addr = 32'hB000_0000;
        exp_q.push_back({1'b1, 32'h0});
        step();
        rd_req = 1'b0;
        n_checks++;
        if (s_sel !== 4'b0000 || m_ready !== 1'b1 || m_err !== 1'b1 || m_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL unmapped: sel=%b rdy=%b err=%b rdata=%h, expected 0000 1 1 00000000",
                     s_sel, m_ready, m_err, m_rdata);
        end
        step();
    endtask

    task automatic test_write_priority();
        wr_req  = 1'b1;
        w_addr  = 32'hC000_0004;
        rd_req  = 1'b1;
        r_addr  = 32'h0000_0000;
        m_wdata = 32'hA5A5_5A5A;
        m_wstrb = 4'b0011;
        s_rdata[2*DW +: DW] = 32'h7777_7777;
        exp_q.push_back({1'b0, 32'h0});
        step();
        wr_req = 1'b0;
        rd_req = 1'b0;
        n_checks++;
        if (s_sel !== 4'b0100 || s_we !== 1'b1 || s_addr !== 32'hC000_0004 ||
            s_wdata !== 32'hA5A5_5A5A || s_wstrb !== 4'b0011) begin
            n_fail++;
            $display("FAIL write_priority: sel=%b we=%b addr=%h wdata=%h wstrb=%b, expected 0100 1 c0000004 a5a55a5a 0011",
                     s_sel, s_we, s_addr, s_wdata, s_wstrb);
        end
        s_ack[2] = 1'b1;
        step();
        s_ack = '0;
        n_checks++;
        if (m_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL write_latency: rdy=%b, expected 1", m_ready);
        end
        step();
    endtask

    task automatic test_timeout();
        int sel_cycles;
        wr_req = 1'b1;
        w_addr = 32'hF000_0010;
        s_rdata[3*DW +: DW] = 32'h3333_3333;
        exp_q.push_back({1'b1, 32'h0});
        step();
        wr_req = 1'b0;
        sel_cycles = 0;
        while (s_sel === 4'b1000 && sel_cycles < 40) begin
            sel_cycles++;
            step();
        end
        n_checks++;
        if (sel_cycles != TO || m_ready !== 1'b1 || m_err !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout: sel held %0d cycles rdy=%b err=%b, expected %0d cycles 1 1",
                     sel_cycles, m_ready, m_err, TO);
        end
        step();
    endtask

    task automatic test_ack_last_cycle();
        rd_req = 1'b1;
        r_addr = 32'hF000_0020;
        s_rdata[3*DW +: DW] = 32'hCAFE_BABE;
        exp_q.push_back({1'b0, 32'hCAFE_BABE});
        step();
        rd_req = 1'b0;
        repeat (TO - 1) step();
        n_checks++;
        if (s_sel !== 4'b1000 || m_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ack_last_pre: sel=%b rdy=%b, expected 1000 0", s_sel, m_ready);
        end
        s_ack[3] = 1'b1;
        step();
        s_ack = '0;
        n_checks++;
        if (m_ready !== 1'b1 || m_err !== 1'b0) begin
            n_fail++;
            $display("FAIL ack_last_cycle: rdy=%b err=%b, expected 1 0", m_ready, m_err);
        end
        step();
    endtask

    task automatic test_stray_ack();
        rd_req = 1'b1;
        r_addr = 32'h0000_2000;
        s_rdata[1*DW +: DW] = 32'h55AA_1234;
        s_rdata[2*DW +: DW] = 32'hDEAD_BEEF;
        exp_q.push_back({1'b0, 32'h55AA_1234});
        step();
        rd_req = 1'b0;
        s_ack[2] = 1'b1;
        step();
        s_ack = '0;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (busy !== 1'b1 || s_sel !== 4'b0010 || m_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL stray_ack_hold[%0d]: busy=%b sel=%b rdy=%b, expected 1 0010 0",
                         k, busy, s_sel, m_ready);
            end
            if (k < 2) step();
        end
        s_ack[1] = 1'b1;
        step();
        s_ack = '0;
        n_checks++;
        if (m_ready !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL stray_ack_resp: rdy=%b busy=%b, expected 1 1", m_ready, busy);
        end
        step();
    endtask

    task automatic test_reset_mid();
        int pulses;
        wr_req = 1'b1;
        w_addr = 32'hF000_0000;
        step();
        wr_req = 1'b0;
        step();
        rst = 1'b1;
        #1;
        n_checks++;
        if (s_sel !== 4'b0000 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_abort: sel=%b busy=%b, expected 0000 0", s_sel, busy);
        end
        step();
        rst = 1'b0;
        pulses = 0;
        repeat (TO + 4) begin
            step();
            if (m_ready === 1'b1) pulses++;
        end
        n_checks++;
        if (pulses != 0) begin
            n_fail++;
            $display("FAIL reset_mid_no_resp: %0d m_ready pulses, expected 0", pulses);
        end
        rd_req = 1'b1;
        r_addr = 32'h0000_3000;
        s_rdata[1*DW +: DW] = 32'h0BAD_F00D;
        exp_q.push_back({1'b0, 32'h0BAD_F00D});
        step();
        rd_req = 1'b0;
        s_ack[1] = 1'b1;
        step();
        s_ack = '0;
        n_checks++;
        if (m_ready !== 1'b1 || m_rdata !== 32'h0BAD_F00D) begin
            n_fail++;
            $display("FAIL reset_mid_recover: rdy=%b rdata=%h, expected 1 0badf00d", m_ready, m_rdata);
        end
        step();
    endtask

    // One transaction: slv < 0 means the address is expected to be unmapped.
    task automatic run_txn(input logic we, input logic [AW-1:0] addr, input int slv,
                           input logic [DW-1:0] data, input int dly);
        if (we) begin
            wr_req = 1'b1;
            w_addr = addr;
        end else begin
            rd_req = 1'b1;
            r_addr = addr;
        end
        if (slv >= 0) s_rdata[slv*DW +: DW] = data;
        exp_q.push_back({(slv < 0), ((we || slv < 0) ? 32'h0 : data)});
        step();
        wr_req = 1'b0;
        rd_req = 1'b0;
        if (slv < 0) begin
            n_checks++;
            if (s_sel !== 4'b0000 || m_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_unmapped %h: sel=%b rdy=%b, expected 0000 1", addr, s_sel, m_ready);
            end
        end else begin
            n_checks++;
            if (s_sel !== (4'b0001 << slv)) begin
                n_fail++;
                $display("FAIL b2b_select %h: sel=%b, expected slot %0d", addr, s_sel, slv);
            end
            repeat (dly) step();
            s_ack[slv] = 1'b1;
            step();
            s_ack = '0;
            n_checks++;
            if (m_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_latency %h: rdy=%b, expected 1", addr, m_ready);
            end
        end
        step();
    endtask

    task automatic test_back_to_back();
        run_txn(1'b0, 32'h0000_0000, 1,  32'h1111_0001, 0);
        run_txn(1'b0, 32'h9FFF_FFFC, 1,  32'h1111_0002, 2);
        run_txn(1'b0, 32'hA000_0000, -1, 32'h0,         0);
        run_txn(1'b1, 32'hC000_0FFC, 2,  32'h2222_0003, 1);
        run_txn(1'b0, 32'hC000_1000, -1, 32'h0,         0);
        run_txn(1'b0, 32'hF000_0FFF, 3,  32'h3333_0004, 3);
        run_txn(1'b1, 32'hF000_1000, -1, 32'h0,         0);
        run_txn(1'b0, 32'hEFFF_FFFF, -1, 32'h0,         0);
        for (int k = 0; k < 4; k++) begin
            run_txn(1'b0, 32'hC000_0000 + {$urandom_range(0, 1023), 2'b00}, 2,
                    $urandom, $urandom_range(0, 4));
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_unmapped();
        test_write_priority();
        test_timeout();
        test_ack_last_cycle();
        test_stray_ack();
        test_reset_mid();
        test_back_to_back();
        repeat (2) step();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d responses never arrived, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
